// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider; without it only multiply is present.
module mul_div_unit (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  input  logic        MtHi,
  input  logic        MtLo,
  input  logic [31:0] MtData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int unsigned W    = 32;
  localparam int unsigned W2   = 2 * W;
  localparam int unsigned CntW = 5;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state;
  logic [CntW-1:0] stepCnt;
  logic            isDiv;
  logic            negRes;
  logic [W2-1:0]   prod;
  logic [W-1:0]    opnd;

  logic            signedOp;
  logic            aNeg;
  logic            bNeg;
  logic [W-1:0]    magA;
  logic [W-1:0]    magB;
  logic [W:0]      mulSum;
  logic [W2-1:0]   mulFix;

  // Operand magnitudes; MULT and DIV (Op[0]=0) are the signed forms.
  always_comb begin
    signedOp = ~Op[0];
    aNeg     = signedOp & OperandA[W-1];
    bNeg     = signedOp & OperandB[W-1];
    magA     = aNeg ? W'(0) - OperandA : OperandA;
    magB     = bNeg ? W'(0) - OperandB : OperandB;
  end

  // Multiply step: prod holds {partial product, remaining multiplier bits}.
  always_comb begin
    mulSum = {1'b0, prod[W2-1:W]} + (prod[0] ? {1'b0, opnd} : (W + 1)'(0));
    mulFix = negRes ? W2'(0) - prod : prod;
  end

`ifdef MULDIV_DIV_EN
  logic         negRem;
  logic [W-1:0] origA;
  logic [W:0]   divShift;
  logic [W:0]   divDiff;
  logic         divFits;
  logic [W-1:0] divRem;
  logic [W-1:0] quotFix;
  logic [W-1:0] remFix;

  // Divide step: prod holds {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    divShift = {prod[W2-1:W], prod[W-1]};
    divDiff  = divShift - {1'b0, opnd};
    divFits  = ~divDiff[W];
    divRem   = divFits ? divDiff[W-1:0] : divShift[W-1:0];
    quotFix  = negRes ? W'(0) - prod[W-1:0] : prod[W-1:0];
    remFix   = negRem ? W'(0) - prod[W2-1:W] : prod[W2-1:W];
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      stepCnt <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      prod    <= '0;
      opnd    <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
`ifdef MULDIV_DIV_EN
      negRem  <= 1'b0;
      origA   <= '0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            isDiv   <= Op[1];
            negRes  <= aNeg ^ bNeg;
            stepCnt <= '0;
            Busy    <= 1'b1;
`ifdef MULDIV_DIV_EN
            negRem  <= aNeg;
            origA   <= OperandA;
            state   <= CALC;
            if (Op[1]) begin
              prod <= {W'(0), magA};
              opnd <= magB;
            end else begin
              prod <= {W'(0), magB};
              opnd <= magA;
            end
`else
            // Divide requests complete immediately without touching HI/LO.
            if (Op[1]) begin
              state <= FIX;
            end else begin
              prod  <= {W'(0), magB};
              opnd  <= magA;
              state <= CALC;
            end
`endif
          end else begin
            if (MtHi) Hi <= MtData;
            if (MtLo) Lo <= MtData;
          end
        end
        CALC: begin
          stepCnt <= stepCnt + CntW'(1);
`ifdef MULDIV_DIV_EN
          if (isDiv) prod <= {divRem, prod[W-2:0], divFits};
          else       prod <= {mulSum, prod[W-1:1]};
`else
          prod <= {mulSum, prod[W-1:1]};
`endif
          if (stepCnt == CntW'(W - 1)) state <= FIX;
        end
        FIX: begin
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
          if (!isDiv) begin
            {Hi, Lo} <= mulFix;
          end else begin
`ifdef MULDIV_DIV_EN
            if (opnd == '0) begin
              Hi <= origA;
              Lo <= '1;
            end else begin
              Hi <= remFix;
              Lo <= quotFix;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO and latency are queued at issue
// and compared when Done appears. Expectations follow MULDIV_DIV_EN.
module tb_mul_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        MtHi;
  logic        MtLo;
  logic [31:0] MtData;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  mul_div_unit dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .MtHi(MtHi), .MtLo(MtLo), .MtData(MtData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  // Reference result using native wide arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, q, r;
    logic [63:0] p, qv, rv;
    e.hi = modelHi; e.lo = modelLo; e.lat = 33;
    case (op)
      2'b00: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        p = 64'(sa * sb);
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          qv = 64'(q); rv = 64'(r);
          e.hi = rv[31:0]; e.lo = qv[31:0];
        end else begin
          e.hi = a % b; e.lo = a / b;
        end
`else
        e.lat = 1;
`endif
      end
    endcase
    return e;
  endfunction

  // Issue one operation and wait (bounded) for Done; optionally disturb it while busy.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, output int lat, output logic busy0,
                        output logic [31:0] hHi, output logic [31:0] hLo);
    sbq.push_back(model(op, a, b));
    @(negedge Clk);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge Clk); #1;
    busy0 = Busy;
    Start = 1'b0; OperandA = $urandom; OperandB = $urandom;
    hHi = Hi; hLo = Lo; lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (disturb && n == 4) begin
        Start = 1'b1; Op = 2'b01; OperandA = 32'h0BAD_0BAD; OperandB = 32'h7777_7777;
        MtHi = 1'b1; MtData = 32'hDEAD_BEEF;
      end
      if (disturb && n == 8) begin
        Start = 1'b0; MtHi = 1'b0;
      end
      @(posedge Clk); #1;
      if (Done) begin
        lat = n;
        break;
      end
      hHi = Hi; hLo = Lo;
    end
    Start = 1'b0; MtHi = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
    MtHi = 1'b0; MtLo = 1'b0; MtData = '0;
    #12;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", Hi); end
    checks++; if (Lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", Lo); end
    @(negedge Clk); Rst_n = 1'b1;
  endtask

  task automatic test_multiply();
    logic [1:0]  ops[6] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
    logic [31:0] as[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0, 32'h1234_5678, 32'hDEAD_BEEF};
    logic [31:0] bs[6]  = '{32'hFFFF_FFFF, 32'h0000_0007, 32'h8000_0000, 32'h5555_5555, 32'hFFFF_FF00, 32'hCAFE_F00D};
    int lat; logic busy0; logic [31:0] hHi, hLo; exp_t e;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, lat, busy0, hHi, hLo);
      e = sbq.pop_front();
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mul%0d_busy got %b want 1", i, busy0); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL mul%0d_latency got %0d want %0d", i, lat, e.lat); end
      checks++; if (hHi !== modelHi || hLo !== modelLo) begin errors++; $display("FAIL mul%0d_hold got %h_%h want %h_%h", i, hHi, hLo, modelHi, modelLo); end
      checks++; if (Hi !== e.hi) begin errors++; $display("FAIL mul%0d_hi got %h want %h", i, Hi, e.hi); end
      checks++; if (Lo !== e.lo) begin errors++; $display("FAIL mul%0d_lo got %h want %h", i, Lo, e.lo); end
      modelHi = e.hi; modelLo = e.lo;
      @(posedge Clk); #1;
      checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL mul%0d_done_pulse got done=%b busy=%b want 0 0", i, Done, Busy); end
    end
  endtask

  task automatic test_divide();
    logic [1:0]  ops[8] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10};
    logic [31:0] as[8]  = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0064};
    logic [31:0] bs[8]  = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'd1, 32'hFFFF_FFF9};
    int lat; logic busy0; logic [31:0] hHi, hLo; exp_t e;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, lat, busy0, hHi, hLo);
      e = sbq.pop_front();
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL div%0d_busy got %b want 1", i, busy0); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL div%0d_latency got %0d want %0d", i, lat, e.lat); end
      checks++; if (hHi !== modelHi || hLo !== modelLo) begin errors++; $display("FAIL div%0d_hold got %h_%h want %h_%h", i, hHi, hLo, modelHi, modelLo); end
      checks++; if (Hi !== e.hi) begin errors++; $display("FAIL div%0d_hi got %h want %h", i, Hi, e.hi); end
      checks++; if (Lo !== e.lo) begin errors++; $display("FAIL div%0d_lo got %h want %h", i, Lo, e.lo); end
      modelHi = e.hi; modelLo = e.lo;
    end
  endtask

  task automatic test_busy_ignore();
    int lat; logic busy0; logic [31:0] hHi, hLo; exp_t e;
    run_op(2'b01, 32'h0001_2345, 32'h0000_0010, 1'b1, lat, busy0, hHi, hLo);
    e = sbq.pop_front();
    checks++; if (lat != e.lat) begin errors++; $display("FAIL busy_ignore_latency got %0d want %0d", lat, e.lat); end
    checks++; if (hHi !== modelHi) begin errors++; $display("FAIL busy_ignore_mthi got %h want %h", hHi, modelHi); end
    checks++; if (Hi !== e.hi || Lo !== e.lo) begin errors++; $display("FAIL busy_ignore_result got %h_%h want %h_%h", Hi, Lo, e.hi, e.lo); end
    modelHi = e.hi; modelLo = e.lo;
    @(posedge Clk); #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_restart got busy=%b want 0", Busy); end
  endtask

  task automatic test_move_to();
    @(negedge Clk); MtLo = 1'b1; MtData = 32'h1234_5678;
    @(posedge Clk); #1; MtLo = 1'b0;
    modelLo = 32'h1234_5678;
    checks++; if (Lo !== modelLo || Hi !== modelHi) begin errors++; $display("FAIL mtlo got %h_%h want %h_%h", Hi, Lo, modelHi, modelLo); end
    checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL mtlo_flags got done=%b busy=%b want 0 0", Done, Busy); end
    @(negedge Clk); MtHi = 1'b1; MtLo = 1'b1; MtData = 32'hA5A5_0F0F;
    @(posedge Clk); #1; MtHi = 1'b0; MtLo = 1'b0;
    modelHi = 32'hA5A5_0F0F; modelLo = 32'hA5A5_0F0F;
    checks++; if (Hi !== modelHi || Lo !== modelLo) begin errors++; $display("FAIL mt_both got %h_%h want %h_%h", Hi, Lo, modelHi, modelLo); end
    // An accepted Start wins over a simultaneous move.
    @(negedge Clk); Start = 1'b1; Op = 2'b01; OperandA = 32'd2; OperandB = 32'd3;
    MtHi = 1'b1; MtData = 32'h0000_BEEF;
    @(posedge Clk); #1; Start = 1'b0; MtHi = 1'b0;
    checks++; if (Hi !== modelHi) begin errors++; $display("FAIL mt_with_start got %h want %h", Hi, modelHi); end
    for (int n = 0; n < 40 && !Done; n++) @(posedge Clk) #1;
    modelHi = 32'd0; modelLo = 32'd6;
    checks++; if (Hi !== modelHi || Lo !== modelLo) begin errors++; $display("FAIL mt_with_start_result got %h_%h want %h_%h", Hi, Lo, modelHi, modelLo); end
  endtask

  task automatic test_reset_abort();
    logic sawDone; int lat; logic busy0; logic [31:0] hHi, hLo; exp_t e;
    @(negedge Clk); Start = 1'b1; Op = 2'b01; OperandA = 32'hFFFF_0000; OperandB = 32'h0000_FFFF;
    @(posedge Clk); #1; Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL abort_flags got busy=%b done=%b want 0 0", Busy, Done); end
    checks++; if (Hi !== 32'd0 || Lo !== 32'd0) begin errors++; $display("FAIL abort_hilo got %h_%h want 0_0", Hi, Lo); end
    modelHi = '0; modelLo = '0;
    @(negedge Clk); Rst_n = 1'b1;
    sawDone = 1'b0;
    repeat (40) begin @(posedge Clk); #1; if (Done || Busy) sawDone = 1'b1; end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("FAIL abort_no_done got activity=%b want 0", sawDone); end
    run_op(2'b01, 32'd3, 32'd4, 1'b0, lat, busy0, hHi, hLo);
    e = sbq.pop_front();
    checks++; if (lat != 33) begin errors++; $display("FAIL abort_next_latency got %0d want 33", lat); end
    checks++; if (Lo !== 32'd12 || Hi !== 32'd0) begin errors++; $display("FAIL abort_next_result got %h_%h want 0_c", Hi, Lo); end
    modelHi = e.hi; modelLo = e.lo;
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_busy_ignore();
    test_move_to();
    test_reset_abort();
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
